// File: rtl/strobe_period_checker.sv
// Checks that strobe arrives every PERIOD clocks for PASS_COUNT intervals.
// Define STROBE_CHECK_TIMEOUT_EN to flag a missing strobe as a timeout.
module strobe_period_checker #(
  parameter int PERIOD     = 5,
  parameter int CNT_W      = 8,
  parameter int PASS_COUNT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             strobe,
  output logic             busy,
  output logic             passed,
  output logic             failed,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] good_cnt
);

  localparam logic [CNT_W-1:0] PER  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] PASS = CNT_W'(PASS_COUNT);
  localparam logic [CNT_W-1:0] MAXC = '1;
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] good_inc;
  logic             busy_q, busy_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [1:0]       err_q, err_d;
  logic             ev_good, ev_early;
  logic             ev_late, ev_to;

  assign good_inc = good_q + 1'b1;

  always_comb begin
    ev_good  = strobe && (cnt_q == PER);
    ev_early = strobe && (cnt_q < PER);
`ifdef STROBE_CHECK_TIMEOUT_EN
    ev_late  = 1'b0;
    ev_to    = !strobe && (cnt_q == PER);
`else
    ev_late  = strobe && (cnt_q > PER);
    ev_to    = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      good_q  <= '0;
      busy_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      good_q  <= good_d;
      busy_q  <= busy_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  state_d = ARMED;
        ARMED: if (strobe) state_d = RUN;
        RUN: begin
          if ((ev_good && good_inc == PASS) ||
              ev_early || ev_late || ev_to)
            state_d = DONE;
        end
        DONE:  state_d = DONE;
      endcase
    end
  end

  // Outputs are computed here and registered with the state.
  always_comb begin
    cnt_d  = cnt_q;
    good_d = good_q;
    pass_d = pass_q;
    fail_d = fail_q;
    err_d  = err_q;
    if (state_d == IDLE) begin
      cnt_d  = '0;
      good_d = '0;
      pass_d = 1'b0;
      fail_d = 1'b0;
      err_d  = 2'b00;
    end else begin
      unique case (state_q)
        ARMED: if (strobe) cnt_d = ONE;
        RUN: begin
          unique case (1'b1)
            ev_good: begin
              good_d = good_inc;
              cnt_d  = ONE;
              pass_d = (good_inc == PASS);
            end
            ev_early: begin
              fail_d = 1'b1;
              err_d  = 2'b01;
            end
            ev_late: begin
              fail_d = 1'b1;
              err_d  = 2'b11;
            end
            ev_to: begin
              fail_d = 1'b1;
              err_d  = 2'b10;
            end
            default: begin
              if (cnt_q != MAXC) cnt_d = cnt_q + 1'b1;
            end
          endcase
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ARMED) || (state_d == RUN);
  end

  assign busy     = busy_q;
  assign passed   = pass_q;
  assign failed   = fail_q;
  assign err_code = err_q;
  assign good_cnt = good_q;

endmodule

// File: tb/tb_strobe_period_checker.sv
// Random and directed bench for strobe_period_checker against an
// interval-based reference model.
module tb_strobe_period_checker;

  localparam int P  = 5;
  localparam int CW = 8;
  localparam int PC = 4;
`ifdef STROBE_CHECK_TIMEOUT_EN
  localparam bit TO = 1'b1;
`else
  localparam bit TO = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          strobe = 1'b0;
  logic          busy, passed, failed;
  logic [1:0]    err_code;
  logic [CW-1:0] good_cnt;

  strobe_period_checker #(
    .PERIOD    (P),
    .CNT_W     (CW),
    .PASS_COUNT(PC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .strobe  (strobe),
    .busy    (busy),
    .passed  (passed),
    .failed  (failed),
    .err_code(err_code),
    .good_cnt(good_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ph: 0 idle, 1 armed, 2 running, 3 done
  typedef struct {
    int     ph;
    int     last;
    int     good;
    bit     pas;
    bit     fal;
    bit [1:0] err;
    bit     busy;
  } m_t;

  m_t m = '{default: 0};
  int cyc = 0;

  function automatic m_t nxt(m_t c, bit r, bit e, bit s, int now);
    m_t n;
    int iv;
    n = c;
    if (!r || !e) begin
      n = '{default: 0};
      return n;
    end
    case (c.ph)
      0: n.ph = 1;
      1: if (s) begin n.ph = 2; n.last = now; end
      2: begin
        iv = now - c.last;
        if (s) begin
          if (iv == P) begin
            n.good = c.good + 1;
            n.last = now;
            if (n.good == PC) begin n.ph = 3; n.pas = 1; end
          end else if (iv < P) begin
            n.ph = 3; n.fal = 1; n.err = 2'b01;
          end else begin
            n.ph = 3; n.fal = 1; n.err = 2'b11;
          end
        end else if (TO && iv == P) begin
          n.ph = 3; n.fal = 1; n.err = 2'b10;
        end
      end
      default: ;
    endcase
    n.busy = (n.ph == 1) || (n.ph == 2);
    return n;
  endfunction

  always @(posedge clk) begin
    m   <= nxt(m, rst_n, en, strobe, cyc);
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("m_busy", busy, m.busy);
      check("m_passed", passed, m.pas);
      check("m_failed", failed, m.fal);
      check("m_err", err_code, m.err);
      check("m_good", good_cnt, m.good);
    end
  end

  task automatic tick(input logic s);
    strobe = s;
    @(negedge clk);
  endtask

  function automatic bit hit(input int q[$], input int k);
    foreach (q[i]) if (q[i] == k) return 1'b1;
    return 1'b0;
  endfunction

  int pq[$] = '{0, 5, 10, 15, 20};
  int eq[$] = '{0, 5, 8};
  int rq[$] = '{0, 5, 10, 15, 20, 25, 30};

  initial begin
    int gap, iv, r;
    bit s;
    @(negedge clk);
    chk_on = 1'b1;
    rst_n = 1'b0; en = 1'b0; strobe = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_passed", passed, 0);
    check("rst_failed", failed, 0);
    check("rst_err", err_code, 0);
    check("rst_good", good_cnt, 0);
    rst_n = 1'b1;

    // pass case
    en = 1'b1; tick(1'b0);
    for (int k = 0; k <= 20; k++) begin
      tick(hit(pq, k));
      if (k == 0) check("arm_busy", busy, 1);
    end
    check("pass_passed", passed, 1);
    check("pass_good", good_cnt, 4);
    check("pass_failed", failed, 0);
    check("pass_busy", busy, 0);

    // en dropped in DONE
    en = 1'b0; tick(1'b0);
    check("drop_passed", passed, 0);
    check("drop_good", good_cnt, 0);
    check("drop_busy", busy, 0);
    en = 1'b1; tick(1'b0);
    check("rearm_busy", busy, 1);

    // early strobe
    for (int k = 0; k <= 8; k++) tick(hit(eq, k));
    check("early_failed", failed, 1);
    check("early_err", err_code, 2'b01);
    check("early_good", good_cnt, 1);
    en = 1'b0; tick(1'b0);
    en = 1'b1; tick(1'b0);

`ifdef STROBE_CHECK_TIMEOUT_EN
    for (int k = 0; k <= 5; k++) tick(k == 0);
    check("to_failed", failed, 1);
    check("to_err", err_code, 2'b10);
`else
    for (int k = 0; k <= 8; k++) begin
      tick(k == 0 || k == 8);
      if (k == 5) begin
        check("late_c5_failed", failed, 0);
        check("late_c5_err", err_code, 0);
      end
    end
    check("late_failed", failed, 1);
    check("late_err", err_code, 2'b11);
`endif
    en = 1'b0; tick(1'b0);
    en = 1'b1; tick(1'b0);

    // reset in the middle of a run
    for (int k = 0; k <= 30; k++) begin
      rst_n = (k != 7);
      tick(hit(rq, k) && k != 7);
      if (k == 7) begin
        check("mid_busy", busy, 0);
        check("mid_good", good_cnt, 0);
        check("mid_passed", passed, 0);
      end
    end
    rst_n = 1'b1;
    check("restart_passed", passed, 1);
    check("restart_good", good_cnt, 4);

    // randomized traffic
    en = 1'b0; tick(1'b0);
    en = 1'b1; tick(1'b0);
    gap = 0;
    iv = P;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 99);
      rst_n = (r != 0);
      en = !(r == 1 || r == 2);
      s = (gap == iv) || (r >= 3 && r <= 5);
      if (s) begin
        gap = 1;
        iv = ($urandom_range(0, 9) < 6) ? P : $urandom_range(2, P + 3);
      end else begin
        gap++;
      end
      tick(s);
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
